// File: rtl/reg_fifo_if.sv
// reg_fifo_if: ready/valid write and read channels plus occupancy status.
// slave is the FIFO side, master is the upstream/consumer side.
interface reg_fifo_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [AW:0]      count;
    logic             full;
    logic             empty;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output count,
        output full,
        output empty
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  count,
        input  full,
        input  empty
    );
endinterface

// File: rtl/reg_fifo.sv
// reg_fifo: DEPTH x WIDTH ready/valid FIFO behind the register-primitive stage.
// REG_FIFO_FALLTHROUGH_EN: an empty FIFO presents in_data combinationally.
module reg_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input logic       clk,
    input logic       reset_n,
    reg_fifo_if.slave bus
);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             full_w;
    logic             empty_w;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             rd_en;

    assign full_w = (cnt == CNT_FULL);
    assign empty_w = (cnt == '0);

    assign bus.count = cnt;
    assign bus.full = full_w;
    assign bus.empty = empty_w;
    assign bus.in_ready = !full_w;

    assign push = bus.in_valid & bus.in_ready;
    assign pop = bus.out_valid & bus.out_ready;

`ifdef REG_FIFO_FALLTHROUGH_EN
    logic bypass;

    // A word taken straight through never touches storage.
    assign bypass = empty_w & bus.in_valid & bus.out_ready;
    assign bus.out_valid = !empty_w | bus.in_valid;
    assign wr_en = push & !bypass;
    assign rd_en = pop & !empty_w;

    always_comb begin
        bus.out_data = '0;
        if (!empty_w)
            bus.out_data = mem[rd_ptr];
        else if (bus.in_valid)
            bus.out_data = bus.in_data;
    end
`else
    assign bus.out_valid = !empty_w;
    assign wr_en = push;
    assign rd_en = pop;
    assign bus.out_data = empty_w ? '0 : mem[rd_ptr];
`endif

    // Storage is never cleared; out_data is gated while empty.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en)
            mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule
